// File: rtl/arb_pkg.sv
// Shared definitions for arbitrated blocks: mode encodings and the
// channel-index width helper.
package arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for n channels; never below 1 so ports stay legal.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority or round-robin from a pointer,
// implemented as a double-width masked priority search.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CH_W     = ch_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_W-1:0]     pointer,
  input  logic                mode,
  output logic [CHANNELS-1:0] grant,
  output logic [CH_W-1:0]     idx,
  output logic                any_grant
);

  logic [CHANNELS-1:0]   masked;
  logic [2*CHANNELS-1:0] dbl;
  int                    base;
  int                    sel;

  // Lower half holds requests at or above the pointer, upper half all
  // requests, so the first set bit is the wrapped search result.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    sel       = 0;
    base      = (mode == MODE_RR) ? int'(pointer) : 0;
    for (int i = 0; i < CHANNELS; i++) begin
      masked[i] = req[i] & (i >= base);
    end
    dbl = {req, masked};
    for (int j = 0; j < 2 * CHANNELS; j++) begin
      if (!any_grant && dbl[j]) begin
        any_grant = 1'b1;
        sel       = (j < CHANNELS) ? j : j - CHANNELS;
      end
    end
    if (any_grant) begin
      grant[sel] = 1'b1;
      idx        = CH_W'(sel);
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Registered N:1 channel multiplexer with fixed-priority or round-robin
// arbitration and valid/ready handshakes on both sides.
module arb_mux
  import arb_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 4,
  parameter int CH_W     = ch_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [CH_W-1:0]           out_ch,
  input  logic                      out_ready
);

  logic [CHANNELS-1:0] grant;
  logic [CH_W-1:0]     grant_idx;
  logic                any_grant;
  logic [CH_W-1:0]     rr_ptr;
  logic                load_en;
  logic                accept;
  logic [WIDTH-1:0]    sel_data;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_arb (
    .req       (in_valid),
    .pointer   (rr_ptr),
    .mode      (mode),
    .grant     (grant),
    .idx       (grant_idx),
    .any_grant (any_grant)
  );

  assign load_en  = ~out_valid | out_ready;
  assign in_ready = grant & {CHANNELS{load_en & ~rst}};
  assign accept   = any_grant & load_en & ~rst;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous, so it
  // lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_ch    <= grant_idx;
        if (mode == MODE_RR) begin
          rr_ptr <= (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: a 4-channel and a 3-channel instance driven
// from one clock with hand-computed expectations.
module tb_arb_mux;

  logic        clk = 1'b0;
  logic        rst;

  logic        mode4, out_ready4, out_valid4;
  logic [3:0]  in_valid4, in_ready4;
  logic [11:0] in_data4;
  logic [2:0]  out_data4;
  logic [1:0]  out_ch4;

  logic        mode3, out_ready3, out_valid3;
  logic [2:0]  in_valid3, in_ready3;
  logic [8:0]  in_data3;
  logic [2:0]  out_data3;
  logic [1:0]  out_ch3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(3), .CHANNELS(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode4),
    .in_valid  (in_valid4),
    .in_data   (in_data4),
    .in_ready  (in_ready4),
    .out_valid (out_valid4),
    .out_data  (out_data4),
    .out_ch    (out_ch4),
    .out_ready (out_ready4)
  );

  arb_mux #(.WIDTH(3), .CHANNELS(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode3),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_ready (out_ready3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    mode4      = 1'b0;
    in_valid4  = 4'b1111;
    in_data4   = '0;
    out_ready4 = 1'b1;
    mode3      = 1'b0;
    in_valid3  = '0;
    in_data3   = '0;
    out_ready3 = 1'b1;

    // Reset with every channel requesting.
    tick;
    check("rst_in_ready", in_ready4, 4'b0000);
    check("rst_out_valid", out_valid4, 1'b0);
    check("rst_out_data", out_data4, 3'd0);
    check("rst_out_ch", out_ch4, 2'd0);

    // Fixed priority after release.
    rst       = 1'b0;
    in_valid4 = 4'b1010;
    in_data4  = {3'd2, 3'd0, 3'd5, 3'd0};
    #1;
    check("fix_in_ready", in_ready4, 4'b0010);
    tick;
    check("fix_out_valid", out_valid4, 1'b1);
    check("fix_out_data", out_data4, 3'd5);
    check("fix_out_ch", out_ch4, 2'd1);
    in_valid4 = 4'b0000;
    tick;
    check("drain_out_valid", out_valid4, 1'b0);
    check("drain_hold_data", out_data4, 3'd5);
    check("drain_hold_ch", out_ch4, 2'd1);

    // Round-robin rotation from pointer 0.
    mode4     = 1'b1;
    in_valid4 = 4'b1111;
    in_data4  = {3'd4, 3'd3, 3'd2, 3'd1};
    #1;
    check("rr_first_ready", in_ready4, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      tick;
      check("rr_out_ch", out_ch4, 32'(k % 4));
      check("rr_out_data", out_data4, 32'(k % 4 + 1));
    end
    tick;
    check("rr_out_ch_5", out_ch4, 2'd1);
    tick;
    check("rr_out_ch_6", out_ch4, 2'd2);

    // Backpressure: held word, no grants, input changes ignored.
    out_ready4 = 1'b0;
    in_data4   = 12'hfff;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", in_ready4, 4'b0000);
      tick;
      check("bp_out_valid", out_valid4, 1'b1);
      check("bp_out_data", out_data4, 3'd3);
      check("bp_out_ch", out_ch4, 2'd2);
    end
    out_ready4 = 1'b1;
    in_data4   = {3'd4, 3'd3, 3'd2, 3'd1};
    #1;
    check("bp_release_ready", in_ready4, 4'b1000);
    tick;
    check("bp_release_ch", out_ch4, 2'd3);
    check("bp_release_data", out_data4, 3'd4);

    // Advance pointer to 2, then switch to fixed priority.
    tick;
    check("adv_ch0", out_ch4, 2'd0);
    tick;
    check("adv_ch1", out_ch4, 2'd1);
    mode4     = 1'b0;
    in_valid4 = 4'b0110;
    #1;
    check("mode_fix_ready", in_ready4, 4'b0010);
    tick;
    check("mode_fix_ch", out_ch4, 2'd1);
    check("mode_fix_data", out_data4, 3'd2);
    mode4 = 1'b1;
    #1;
    check("mode_rr_ptr_held", in_ready4, 4'b0100);

    // Reset while a word is held.
    rst        = 1'b1;
    out_ready4 = 1'b0;
    #1;
    check("midrst_in_ready", in_ready4, 4'b0000);
    tick;
    check("midrst_out_valid", out_valid4, 1'b0);
    check("midrst_out_data", out_data4, 3'd0);
    rst        = 1'b0;
    in_valid4  = 4'b1111;
    out_ready4 = 1'b1;
    #1;
    check("midrst_ptr_zero", in_ready4, 4'b0001);
    tick;
    check("midrst_next_ch", out_ch4, 2'd0);

    // Three channels: pointer wraps from index 2 back to 0.
    mode3     = 1'b1;
    in_valid3 = 3'b100;
    in_data3  = {3'd6, 3'd2, 3'd1};
    #1;
    check("c3_ready_ch2", in_ready3, 3'b100);
    tick;
    check("c3_out_ch2", out_ch3, 2'd2);
    check("c3_out_data2", out_data3, 3'd6);
    in_valid3 = 3'b111;
    #1;
    check("c3_wrap_ready", in_ready3, 3'b001);
    tick;
    check("c3_wrap_ch", out_ch3, 2'd0);
    check("c3_wrap_data", out_data3, 3'd1);
    check("c3_next_ready", in_ready3, 3'b010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
